apb_slave_access_ctrl: RTL and testbench
========================================

// Module: apb_slave_access_ctrl
// PURPOSE
//  Per-peripheral APB3 slave transfer sequencer for the APB subsystem (watchdog, SPI).
//  Decodes each APB transfer, forwards it to the peripheral register backend over a
//  req/ack handshake, inserts wait states and drives PREADY/PSLVERR.
//  State register uses apb_pkg::states_t (IDLE=2'b00, NOT_READY=2'b10, ERROR=2'b11).
// PARAMETERS
//  ADDR_W      12      PADDR/bk_addr width
//  DATA_W      32      PWDATA/PRDATA/bk data width
//  ADDR_LIMIT  12'h0FC highest legal byte address; above it -> error response
//  TIMEOUT     16      max NOT_READY cycles before forced error (>=1; used only with macro)
// PORTS
//  PCLK      in   1       clock; all logic rising-edge
//  PRESET    in   1       synchronous, active-high reset
//  PSEL      in   1       APB select
//  PENABLE   in   1       APB access phase
//  PWRITE    in   1       1=write, 0=read
//  PADDR     in   ADDR_W  byte address
//  PWDATA    in   DATA_W  write data
//  PRDATA    out  DATA_W  read data, valid when PREADY & PSEL & PENABLE
//  PREADY    out  1       transfer complete
//  PSLVERR   out  1       error response, valid only with PREADY
//  bk_req    out  1       backend request, level, held until bk_ack
//  bk_write  out  1       latched PWRITE
//  bk_addr   out  ADDR_W  latched PADDR
//  bk_wdata  out  DATA_W  latched PWDATA
//  bk_rdata  in   DATA_W  backend read data, valid with bk_ack
//  bk_ack    in   1       backend completion (one-cycle pulse)
//  bk_err    in   1       backend error, sampled with bk_ack
//  state_o   out  2       current states_t value (debug)
// BEHAVIOUR
//  Reset: state IDLE, PREADY=1, PSLVERR=0, PRDATA=0, bk_req=0, bk_write/addr/wdata=0, timer=0.
//  Setup cycle = PSEL & ~PENABLE, only acted on in IDLE; latches PWRITE/PADDR/PWDATA into bk_*.
//  Illegal = PADDR>ADDR_LIMIT or PADDR[1:0]!=0 (decoded from PADDR, not latches).
//  IDLE: setup & legal -> NOT_READY; setup & illegal -> ERROR; else stay. PREADY=1, PSLVERR=0.
//  NOT_READY: bk_req=1. PREADY=bk_ack (comb); PSLVERR=bk_ack&bk_err; PRDATA=bk_rdata when
//   bk_ack & ~bk_write, else 0. bk_ack -> IDLE. ~PSEL (master abort) -> IDLE, bk_req drops,
//   no response. bk_ack and abort same cycle: ack wins, -> IDLE.
//  ERROR: PREADY=1, PSLVERR=1, PRDATA=0, bk_req=0; unconditional -> IDLE next cycle.
//  Latency: combinational ack in first access cycle = zero wait states; each cycle without
//   bk_ack adds one wait state. Back-to-back setup after completion accepted (IDLE).
//  bk_ack outside NOT_READY ignored (late ack after timeout/abort has no effect).
//  Write data never reaches backend for illegal transfers (bk_req never asserted).
//  Reset mid-transfer: immediate return to reset values, pending request dropped.
// CONFIGURATION
//  APB_CTRL_TIMEOUT_EN defined: $clog2(TIMEOUT+1)-bit timer cleared on NOT_READY entry,
//   +1 per NOT_READY cycle without bk_ack; at TIMEOUT-1 without ack -> ERROR next cycle
//   (bk_req low from that cycle); bk_ack in that same cycle completes normally.
//  Not defined: no timer logic; NOT_READY held until bk_ack or abort; TIMEOUT unused.
// TESTING
//  Write 0x10 data 0xA5A5_0001, bk_ack in 1st access cycle -> PREADY=1, PSLVERR=0, 0 waits,
//   bk_addr=0x10, bk_wdata=0xA5A5_0001, bk_req high exactly 1 cycle.
//  Read 0x20, bk_ack after 3 cycles, bk_rdata=0x1234_5678 -> 3 waits, PRDATA=0x1234_5678
//   in PREADY cycle, state_o 2'b10 during waits.
//  Read 0x100 (>ADDR_LIMIT) and write 0x02 (misaligned) -> ERROR, PREADY=1 PSLVERR=1
//   0 waits, bk_req never asserted.
//  bk_ack with bk_err=1 on write 0x04 -> PREADY=1, PSLVERR=1 same cycle, return IDLE.
//  Macro on, TIMEOUT=16, no ack -> 16 NOT_READY cycles then ERROR cycle with PSLVERR=1;
//   late bk_ack next cycle ignored. Macro off -> waits 100 cycles, completes on ack.
//  PRESET asserted in 2nd wait cycle -> next edge state IDLE, bk_req=0, PREADY=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB subsystem types.
// The state encoding is visible on state_o for debug, so the values are fixed here.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    NOT_READY = 2'b10,
    ERROR     = 2'b11
  } states_t;

endpackage

// File: rtl/apb_slave_access_ctrl.sv
// APB3 slave transfer sequencer: decodes a transfer and hands it to a register backend over req/ack.
// Latency: zero wait states when bk_ack arrives in the first access cycle, +1 wait per cycle without ack.
// Backpressure: PREADY held low while the backend has not acked; master abort (PSEL low) cancels.
// Optional APB_CTRL_TIMEOUT_EN: bounds NOT_READY to TIMEOUT cycles, then forces an error response.
module apb_slave_access_ctrl #(
  parameter int                 ADDR_W     = 12,
  parameter int                 DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  ADDR_LIMIT = 'h0FC,
  parameter int                 TIMEOUT    = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              bk_req,
  output logic              bk_write,
  output logic [ADDR_W-1:0] bk_addr,
  output logic [DATA_W-1:0] bk_wdata,
  input  logic [DATA_W-1:0] bk_rdata,
  input  logic              bk_ack,
  input  logic              bk_err,
  output logic [1:0]        state_o
);

  import apb_pkg::*;

  states_t           state_q;
  logic              bk_write_q;
  logic [ADDR_W-1:0] bk_addr_q;
  logic [DATA_W-1:0] bk_wdata_q;

  logic setup;
  logic illegal;

  // A new transfer is only recognised in its setup phase.
  assign setup   = PSEL & ~PENABLE;
  // Decoded from the live bus so the decision is ready at the setup edge.
  assign illegal = (PADDR > ADDR_LIMIT) || (PADDR[1:0] != 2'b00);

`ifdef APB_CTRL_TIMEOUT_EN
  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] timer_q;
`else
  // TIMEOUT only matters when the watchdog timer is built in.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  // Transfer sequencer: captures the request, waits for the backend, returns to IDLE.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      bk_write_q <= 1'b0;
      bk_addr_q  <= '0;
      bk_wdata_q <= '0;
`ifdef APB_CTRL_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (setup) begin
            bk_write_q <= PWRITE;
            bk_addr_q  <= PADDR;
            bk_wdata_q <= PWDATA;
            state_q    <= illegal ? ERROR : NOT_READY;
`ifdef APB_CTRL_TIMEOUT_EN
            timer_q    <= '0;
`endif
          end
        end
        NOT_READY: begin
          // Ack has priority over both abort and timeout.
          if (bk_ack) begin
            state_q <= IDLE;
          end else if (!PSEL) begin
            state_q <= IDLE;
`ifdef APB_CTRL_TIMEOUT_EN
          end else if (timer_q == TIMER_LAST) begin
            state_q <= ERROR;
          end else begin
            timer_q <= timer_q + TW'(1);
`endif
          end
        end
        ERROR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Bus responses follow the state; completion in NOT_READY is passed straight through from the backend.
  always_comb begin
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    bk_req  = 1'b0;
    case (state_q)
      NOT_READY: begin
        bk_req  = 1'b1;
        PREADY  = bk_ack;
        PSLVERR = bk_ack & bk_err;
        if (bk_ack && !bk_write_q) begin
          PRDATA = bk_rdata;
        end
      end
      ERROR: begin
        PSLVERR = 1'b1;
      end
      default: begin
        PREADY = 1'b1;
      end
    endcase
  end

  assign bk_write = bk_write_q;
  assign bk_addr  = bk_addr_q;
  assign bk_wdata = bk_wdata_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_apb_slave_access_ctrl.sv
// Directed bench for apb_slave_access_ctrl: drives APB transfers and a scripted backend.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Build with APB_CTRL_TIMEOUT_EN defined to exercise the timeout path instead of the long wait.
module tb_apb_slave_access_ctrl;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        bk_req;
  logic        bk_write;
  logic [11:0] bk_addr;
  logic [31:0] bk_wdata;
  logic [31:0] bk_rdata;
  logic        bk_ack;
  logic        bk_err;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  apb_slave_access_ctrl #(
    .ADDR_W(12), .DATA_W(32), .ADDR_LIMIT(12'h0FC), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .bk_req(bk_req), .bk_write(bk_write), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
    .bk_rdata(bk_rdata), .bk_ack(bk_ack), .bk_err(bk_err), .state_o(state_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_step();
    @(posedge PCLK);
    #1;
  endtask

  // One full transfer: setup, access cycles until PREADY (ack after ack_after waits, -1 = never), teardown.
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                      input int ack_after, input logic err, input logic [31:0] rd,
                      output int waits, output logic [31:0] prdata, output logic slverr,
                      output logic [1:0] st_done, output int req_cycles, output int nr_cycles);
    int cyc;
    bit done;
    req_cycles = 0;
    nr_cycles  = 0;
    prdata     = '0;
    slverr     = 1'b0;
    st_done    = 2'b00;
    drive_step();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    bk_ack = 1'b0; bk_err = 1'b0; bk_rdata = 32'hDEAD_BEEF;
    @(negedge PCLK);
    if (bk_req) req_cycles++;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 300) begin
      drive_step();
      PENABLE = 1'b1;
      if (ack_after >= 0 && cyc == ack_after) begin
        bk_ack = 1'b1; bk_err = err; bk_rdata = rd;
      end else begin
        bk_ack = 1'b0; bk_err = 1'b0; bk_rdata = 32'hDEAD_BEEF;
      end
      @(negedge PCLK);
      if (bk_req) req_cycles++;
      if (state_o == 2'b10) nr_cycles++;
      if (PREADY) begin
        done    = 1'b1;
        prdata  = PRDATA;
        slverr  = PSLVERR;
        st_done = state_o;
      end else begin
        cyc++;
      end
    end
    waits = cyc;
    if (!done) check("xfer_bound_expired", 64'd0, 64'd1);
    drive_step();
    PSEL = 1'b0; PENABLE = 1'b0; bk_ack = 1'b0; bk_err = 1'b0;
    @(negedge PCLK);
    if (bk_req) req_cycles++;
  endtask

  int          waits, reqs, nrs;
  logic [31:0] rdat;
  logic        serr;
  logic [1:0]  sdone;

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    bk_rdata = '0; bk_ack = 1'b0; bk_err = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_state", state_o, 2'b00);
    check("rst_pready", PREADY, 1'b1);
    check("rst_pslverr", PSLVERR, 1'b0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_bk_req", bk_req, 1'b0);
    check("rst_bk_addr", bk_addr, 12'h0);
    check("rst_bk_wdata", bk_wdata, 32'h0);
    check("rst_bk_write", bk_write, 1'b0);
    drive_step();
    PRESET = 1'b0;

    // Zero-wait write
    xfer(1'b1, 12'h010, 32'hA5A5_0001, 0, 1'b0, 32'h0, waits, rdat, serr, sdone, reqs, nrs);
    check("wr_waits", waits, 0);
    check("wr_pslverr", serr, 1'b0);
    check("wr_req_cycles", reqs, 1);
    check("wr_bk_addr", bk_addr, 12'h010);
    check("wr_bk_wdata", bk_wdata, 32'hA5A5_0001);
    check("wr_bk_write", bk_write, 1'b1);
    check("wr_prdata", rdat, 32'h0);
    check("wr_idle_after", state_o, 2'b00);

    // Read with three wait states
    xfer(1'b0, 12'h020, 32'h0, 3, 1'b0, 32'h1234_5678, waits, rdat, serr, sdone, reqs, nrs);
    check("rd_waits", waits, 3);
    check("rd_prdata", rdat, 32'h1234_5678);
    check("rd_pslverr", serr, 1'b0);
    check("rd_notready_cycles", nrs, 4);
    check("rd_req_cycles", reqs, 4);
    check("rd_bk_addr", bk_addr, 12'h020);

    // Out-of-range read
    xfer(1'b0, 12'h100, 32'h0, -1, 1'b0, 32'h0, waits, rdat, serr, sdone, reqs, nrs);
    check("oor_waits", waits, 0);
    check("oor_pslverr", serr, 1'b1);
    check("oor_state", sdone, 2'b11);
    check("oor_req_cycles", reqs, 0);
    check("oor_prdata", rdat, 32'h0);

    // Misaligned write
    xfer(1'b1, 12'h002, 32'h5555_AAAA, -1, 1'b0, 32'h0, waits, rdat, serr, sdone, reqs, nrs);
    check("mis_waits", waits, 0);
    check("mis_pslverr", serr, 1'b1);
    check("mis_state", sdone, 2'b11);
    check("mis_req_cycles", reqs, 0);

    // Backend error on write
    xfer(1'b1, 12'h004, 32'h0000_0077, 0, 1'b1, 32'h0, waits, rdat, serr, sdone, reqs, nrs);
    check("berr_waits", waits, 0);
    check("berr_pslverr", serr, 1'b1);
    check("berr_state", sdone, 2'b10);
    check("berr_idle_after", state_o, 2'b00);

`ifdef APB_CTRL_TIMEOUT_EN
    // No ack: 16 NOT_READY cycles, then an error cycle
    xfer(1'b0, 12'h0FC, 32'h0, -1, 1'b0, 32'h0, waits, rdat, serr, sdone, reqs, nrs);
    check("to_waits", waits, 16);
    check("to_notready_cycles", nrs, 16);
    check("to_pslverr", serr, 1'b1);
    check("to_state", sdone, 2'b11);
    check("to_req_cycles", reqs, 16);
`else
    // Long wait at the highest legal address
    xfer(1'b0, 12'h0FC, 32'h0, 100, 1'b0, 32'hCAFE_F00D, waits, rdat, serr, sdone, reqs, nrs);
    check("long_waits", waits, 100);
    check("long_prdata", rdat, 32'hCAFE_F00D);
    check("long_pslverr", serr, 1'b0);
    check("long_notready_cycles", nrs, 101);
`endif
    // Late ack while idle has no effect
    drive_step();
    bk_ack = 1'b1; bk_err = 1'b1;
    @(negedge PCLK);
    check("late_ack_pslverr", PSLVERR, 1'b0);
    check("late_ack_bk_req", bk_req, 1'b0);
    drive_step();
    bk_ack = 1'b0; bk_err = 1'b0;
    @(negedge PCLK);
    check("late_ack_state", state_o, 2'b00);

    // Master abort after one wait
    drive_step();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h008;
    drive_step();
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("abort_wait_pready", PREADY, 1'b0);
    drive_step();
    PSEL = 1'b0; PENABLE = 1'b0;
    drive_step();
    bk_ack = 1'b1;
    @(negedge PCLK);
    check("abort_state", state_o, 2'b00);
    check("abort_bk_req", bk_req, 1'b0);
    check("abort_pslverr", PSLVERR, 1'b0);
    drive_step();
    bk_ack = 1'b0;

    // Reset asserted in the second wait cycle
    drive_step();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h030; PWDATA = 32'h0BAD_0BAD;
    drive_step();
    PENABLE = 1'b1;
    drive_step();
    PRESET = 1'b1;
    @(negedge PCLK);
    check("rstmid_before", state_o, 2'b10);
    drive_step();
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check("rstmid_state", state_o, 2'b00);
    check("rstmid_bk_req", bk_req, 1'b0);
    check("rstmid_pready", PREADY, 1'b1);
    check("rstmid_bk_addr", bk_addr, 12'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
